// File: rtl/axi_rt_pkg.sv
// Purpose : shared types for RT-unit reconfiguration (config struct, controller state, reset config).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: rt_cfg_t config struct, rt_ctrl_state_e controller states, RtCfgReset bypass config.
package axi_rt_pkg;

  localparam int unsigned NumAddrRegions = 2;
  localparam int unsigned PeriodWidth    = 32;
  localparam int unsigned BudgetWidth    = 32;
  localparam int unsigned LenWidth       = 8;

  typedef logic [LenWidth-1:0]    len_t;
  typedef logic [BudgetWidth-1:0] budget_t;
  typedef logic [PeriodWidth-1:0] period_t;

  typedef struct packed {
    logic                           rt_enable;
    logic                           imtu_enable;
    len_t                           len_limit;
    budget_t [NumAddrRegions-1:0]   w_budget;
    budget_t [NumAddrRegions-1:0]   r_budget;
    period_t [NumAddrRegions-1:0]   w_period;
    period_t [NumAddrRegions-1:0]   r_period;
  } rt_cfg_t;

  typedef enum logic [2:0] {
    RtIdle    = 3'd0,
    RtIsolate = 3'd1,
    RtDrain   = 3'd2,
    RtApply   = 3'd3,
    RtReload  = 3'd4,
    RtRelease = 3'd5
  } rt_ctrl_state_e;

  // Unit bypassed, no length limiting, all budgets/periods zero.
  localparam rt_cfg_t RtCfgReset = '{
    rt_enable:   1'b0,
    imtu_enable: 1'b0,
    len_limit:   8'hFF,
    w_budget:    '0,
    r_budget:    '0,
    w_period:    '0,
    r_period:    '0
  };

endpackage

// File: rtl/axi_rt_reconfig_ctrl.sv
// Purpose : atomically swaps the active RT-unit config: isolate, drain, apply, reload periods, release.
// Latency : commit to done_o >= 6 cycles inclusive; waits on isolated_i and the write-buffer drain.
// Backpressure: commits while busy are dropped; optional timeout aborts ISOLATE/DRAIN without applying.
// Ports   : clk_i/rst_ni; commit_i, shd_cfg_i, timeout_i (control in); act_cfg_o, imtu_abort_o (to unit);
//           isolate_o/isolated_i (upstream isolate handshake); num_w/aw_pending_i (unit drain status);
//           busy_o, done_o, timeout_err_o (status).
module axi_rt_reconfig_ctrl
  import axi_rt_pkg::*;
#(
  parameter int unsigned IdxWWidth    = 4,
  parameter int unsigned IdxAwWidth   = 3,
  parameter int unsigned TimeoutWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    commit_i,
  input  logic [TimeoutWidth-1:0] timeout_i,
  input  rt_cfg_t                 shd_cfg_i,
  output rt_cfg_t                 act_cfg_o,
  output logic                    imtu_abort_o,
  output logic                    isolate_o,
  input  logic                    isolated_i,
  input  logic [IdxWWidth-1:0]    num_w_pending_i,
  input  logic [IdxAwWidth-1:0]   num_aw_pending_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_err_o
);

  rt_ctrl_state_e          state_q, state_d;
  rt_cfg_t                 pend_q, pend_d;
  rt_cfg_t                 act_q, act_d;
  logic                    err_q, err_d;
  logic [TimeoutWidth-1:0] timer_q, timer_d;

  // A nonzero load never reaches 0 before expiring at 1, so timer_q==0 means "no timeout".
  logic timer_expire;
  logic drained;
  assign timer_expire = (timer_q == TimeoutWidth'(1));
  assign drained      = (num_w_pending_i == '0) && (num_aw_pending_i == '0);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RtIdle;
      pend_q  <= RtCfgReset;
      act_q   <= RtCfgReset;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    act_d   = act_q;
    err_d   = err_q;
    timer_d = timer_q;
    unique case (state_q)
      RtIdle: begin
        if (commit_i) begin
          pend_d  = shd_cfg_i;
          err_d   = 1'b0;
          timer_d = timeout_i;
          state_d = RtIsolate;
        end
      end
      RtIsolate, RtDrain: begin
        // Expiry wins over progress in the same cycle; the applied config stays untouched.
        if (timer_expire) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = RtRelease;
        end else begin
          if (timer_q != '0) timer_d = timer_q - TimeoutWidth'(1);
          if (state_q == RtIsolate) begin
            if (isolated_i) state_d = RtDrain;
          end else if (drained) begin
            state_d = RtApply;
          end
        end
      end
      RtApply: begin
        act_d   = pend_q;
        state_d = RtReload;
      end
      RtReload: begin
        state_d = RtRelease;
      end
      RtRelease: begin
        if (!isolated_i) state_d = RtIdle;
      end
      default: begin
        state_d = RtIdle;
      end
    endcase
  end

  // Outputs
  always_comb begin
    isolate_o    = 1'b0;
    imtu_abort_o = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      RtIsolate, RtDrain, RtApply: isolate_o = 1'b1;
      RtReload: begin
        isolate_o    = 1'b1;
        imtu_abort_o = 1'b1;
      end
      RtRelease: done_o = !isolated_i && !err_q;
      default: ;
    endcase
  end

  assign busy_o        = (state_q != RtIdle);
  assign act_cfg_o     = act_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_axi_rt_reconfig_ctrl.sv
// Purpose : self-checking bench for axi_rt_reconfig_ctrl; sequence-level model plus directed timing pins.
// Latency : n/a.
// Backpressure: environment models an axi_isolate with programmable rise/fall delay and drain hold.
module tb_axi_rt_reconfig_ctrl;
  import axi_rt_pkg::*;

  localparam int TW  = 16;
  localparam int WW  = 4;
  localparam int AWW = 3;
  localparam int CW  = $bits(rt_cfg_t);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            commit_i;
  logic [TW-1:0]   timeout_i;
  rt_cfg_t         shd_cfg_i;
  rt_cfg_t         act_cfg_o;
  logic            imtu_abort_o, isolate_o, isolated_i;
  logic [WW-1:0]   num_w;
  logic [AWW-1:0]  num_aw;
  logic            busy_o, done_o, timeout_err_o;

  always #5 clk = ~clk;

  axi_rt_reconfig_ctrl #(
    .IdxWWidth(WW), .IdxAwWidth(AWW), .TimeoutWidth(TW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .commit_i(commit_i), .timeout_i(timeout_i),
    .shd_cfg_i(shd_cfg_i), .act_cfg_o(act_cfg_o), .imtu_abort_o(imtu_abort_o),
    .isolate_o(isolate_o), .isolated_i(isolated_i), .num_w_pending_i(num_w),
    .num_aw_pending_i(num_aw), .busy_o(busy_o), .done_o(done_o), .timeout_err_o(timeout_err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Environment knobs
  int         env_rise = 0, env_fall = 0, env_hold = 0, env_cnt = 0, drain_left = 0;
  bit         env_block = 0, env_rand = 0;
  logic [WW-1:0]  env_w  = '0;
  logic [AWW-1:0] env_aw = '0;

  // Model: one reconfiguration sequence described by cycle timestamps relative to commit
  bit      m_busy, m_err;
  int      m_n, m_isoN, m_drainN, m_relN, m_T;
  rt_cfg_t m_act, m_pend;
  rt_cfg_t reset_cfg;

  // Observed pulses
  int done_cnt = 0, abort_cnt = 0, last_done = -1, last_abort = -1;

  task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, got, exp);
    end
  endtask

  function automatic rt_cfg_t rand_cfg();
    rt_cfg_t c;
    c.rt_enable   = 1'($urandom_range(0, 1));
    c.imtu_enable = 1'($urandom_range(0, 1));
    c.len_limit   = len_t'($urandom);
    for (int i = 0; i < NumAddrRegions; i++) begin
      c.w_budget[i] = budget_t'($urandom);
      c.r_budget[i] = budget_t'($urandom);
      c.w_period[i] = period_t'($urandom);
      c.r_period[i] = period_t'($urandom);
    end
    return c;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_n = 0; m_isoN = 0; m_drainN = 0; m_relN = 0; m_T = 0;
    m_act = reset_cfg; m_pend = reset_cfg;
  endtask

  // Advance the model across one clock edge using the inputs presented during the cycle.
  task automatic model_edge();
    if (rst_n) begin
      if (!m_busy) begin
        if (commit_i) begin
          m_busy = 1; m_n = 1; m_pend = shd_cfg_i; m_err = 0; m_T = int'(timeout_i);
          m_isoN = 0; m_drainN = 0; m_relN = 0;
        end
      end else begin
        if (m_relN != 0) begin
          if (!isolated_i) m_busy = 0;
        end else if (m_drainN != 0) begin
          if (m_n == m_drainN + 1) m_act = m_pend;
          else if (m_n == m_drainN + 2) m_relN = m_n + 1;
        end else if (m_T != 0 && m_n == m_T) begin
          m_err = 1; m_relN = m_n + 1;
        end else if (m_isoN == 0) begin
          if (isolated_i) m_isoN = m_n;
        end else if (num_w == 0 && num_aw == 0) begin
          m_drainN = m_n;
        end
        m_n++;
      end
    end
  endtask

  task automatic env_drive();
    bit want;
    if (drain_left > 0) begin
      num_aw = (env_aw != 0) ? env_aw : AWW'($urandom_range(1, 7));
      num_w  = (env_w  != 0) ? env_w  : WW'($urandom_range(1, 15));
      drain_left--;
    end else if (!isolated_i) begin
      num_aw = AWW'($urandom);
      num_w  = WW'($urandom);
    end else begin
      num_aw = '0;
      num_w  = '0;
    end
    want = isolate_o && !env_block;
    if (want != isolated_i) begin
      env_cnt++;
      if (env_cnt >= (want ? env_rise : env_fall)) begin
        isolated_i = want;
        env_cnt    = 0;
        if (want) drain_left = env_hold;
        if (env_rand) begin
          env_rise = $urandom_range(0, 4);
          env_fall = $urandom_range(0, 4);
          env_hold = $urandom_range(0, 5);
        end
      end
    end else begin
      env_cnt = 0;
    end
  endtask

  task automatic compare();
    bit rel;
    rel = m_busy && (m_relN != 0);
    chk("act_cfg",     act_cfg_o,          m_act);
    chk("isolate",     CW'(isolate_o),     CW'(m_busy && !rel));
    chk("busy",        CW'(busy_o),        CW'(m_busy));
    chk("imtu_abort",  CW'(imtu_abort_o),  CW'(m_busy && m_drainN != 0 && m_n == m_drainN + 2));
    chk("done",        CW'(done_o),        CW'(rel && !isolated_i && !m_err));
    chk("timeout_err", CW'(timeout_err_o), CW'(m_err));
    if (done_o) begin done_cnt++; last_done = cyc; end
    if (imtu_abort_o) begin abort_cnt++; last_abort = cyc; end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    commit_i = 1'b0;
    env_drive();
    @(negedge clk);
    compare();
  endtask

  task automatic start_commit(input rt_cfg_t c, input logic [TW-1:0] t, output int t0);
    shd_cfg_i = c; timeout_i = t; commit_i = 1'b1;
    t0 = cyc; done_cnt = 0; abort_cnt = 0;
  endtask

  initial begin
    rt_cfg_t cfg1, cfg2, cfg3;
    int t0;
    rst_n = 1'b0; commit_i = 1'b0; timeout_i = '0; shd_cfg_i = '0;
    isolated_i = 1'b0; num_w = '0; num_aw = '0;
    reset_cfg = '0;
    reset_cfg.len_limit = 8'hFF;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state pinned to literals
    chk("rst_act_cfg", act_cfg_o, reset_cfg);
    chk("rst_rt_en",   CW'(act_cfg_o.rt_enable), CW'(0));
    chk("rst_len",     CW'(act_cfg_o.len_limit), CW'(8'hFF));
    chk("rst_iso",     CW'(isolate_o), CW'(0));
    chk("rst_busy",    CW'(busy_o), CW'(0));

    // Commit with isolation after 3 cycles, immediate drain; a second commit while busy is dropped
    env_rise = 3; env_fall = 1; env_hold = 0;
    cfg1 = rand_cfg();
    cfg1.w_budget[0] = budget_t'(256);
    start_commit(cfg1, '0, t0);
    step();
    cfg2 = cfg1;
    cfg2.len_limit = ~cfg1.len_limit;
    cfg2.w_budget[1] = ~cfg1.w_budget[1];
    shd_cfg_i = cfg2; commit_i = 1'b1;
    step();
    repeat (8) step();
    chk("t1_abort_cyc", CW'(last_abort - t0), CW'(6));
    chk("t1_done_cyc",  CW'(last_done - t0),  CW'(7));
    chk("t1_abort_cnt", CW'(abort_cnt), CW'(1));
    chk("t1_done_cnt",  CW'(done_cnt),  CW'(1));
    chk("t1_act",       act_cfg_o, cfg1);
    chk("t1_wbud0",     CW'(act_cfg_o.w_budget[0]), CW'(256));
    chk("t1_terr",      CW'(timeout_err_o), CW'(0));

    // Minimum latency: isolate handshake and drain immediate
    env_rise = 0; env_fall = 0;
    start_commit(rand_cfg(), '0, t0);
    repeat (8) step();
    chk("t2_abort_cyc", CW'(last_abort - t0), CW'(4));
    chk("t2_done_cyc",  CW'(last_done - t0),  CW'(5));

    // Drain hold: 2 AW / 5 W pending for 10 DRAIN cycles
    env_rise = 1; env_fall = 1; env_hold = 10; env_aw = 3'd2; env_w = 4'd5;
    cfg3 = rand_cfg();
    start_commit(cfg3, '0, t0);
    repeat (18) step();
    chk("t3_abort_cyc", CW'(last_abort - t0), CW'(14));
    chk("t3_done_cyc",  CW'(last_done - t0),  CW'(15));
    chk("t3_act",       act_cfg_o, cfg3);
    env_aw = '0; env_w = '0; env_hold = 0;

    // Timeout: isolation never granted
    env_block = 1;
    start_commit(rand_cfg(), 16'd4, t0);
    repeat (5) step();
    chk("t4_terr_set",  CW'(timeout_err_o), CW'(1));
    chk("t4_iso_rel",   CW'(isolate_o), CW'(0));
    step();
    chk("t4_busy_end",  CW'(busy_o), CW'(0));
    chk("t4_done_cnt",  CW'(done_cnt), CW'(0));
    chk("t4_abort_cnt", CW'(abort_cnt), CW'(0));
    chk("t4_act_kept",  act_cfg_o, cfg3);
    env_block = 0;

    // Next accepted commit clears the sticky error
    env_rise = 2;
    start_commit(rand_cfg(), '0, t0);
    step();
    chk("t5_terr_clr",  CW'(timeout_err_o), CW'(0));
    repeat (15) step();

    // Reset while in DRAIN
    env_rise = 1; env_hold = 10;
    start_commit(rand_cfg(), '0, t0);
    repeat (5) step();
    chk("t6_in_drain",  CW'(isolate_o), CW'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_arst_iso",  CW'(isolate_o), CW'(0));
    chk("t6_arst_act",  act_cfg_o, reset_cfg);
    chk("t6_arst_busy", CW'(busy_o), CW'(0));
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (8) step();
    chk("t6_no_done",   CW'(done_cnt), CW'(0));
    env_hold = 0;

    // Randomized traffic against the model
    env_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      commit_i  = ($urandom_range(0, 3) == 0);
      shd_cfg_i = rand_cfg();
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       timeout_i = '0;
          1:       timeout_i = TW'($urandom_range(1, 4));
          2:       timeout_i = TW'($urandom_range(5, 12));
          default: timeout_i = TW'(1000);
        endcase
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
